pipe_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with dual-sign-bit overflow detection, optional saturation, sticky overflow flags and valid/ready flow control. It generalises the datapath combinational adder to any width and splits the carry chain across a configurable number of register stages, so it can sit in the EX stage or in multi-cycle arithmetic units without limiting clock frequency.

---
 rtl/pipe_addsub.sv | 170 +++++++++++++++++
 tb/tb_pipe_addsub.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// pipe_addsub
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// STAGES equal slices with one register stage per slice. Overflow is found
// from a one-bit sign extension of the operands. Optional saturation and
// sticky overflow flags are included. All stages share one stall signal.
//
// Parameters
//   WIDTH   operand/result width (>= 2), divisible by STAGES
//   STAGES  pipeline depth / carry-chain slice count (1..4)
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, op)
//   op                  00 add, 01 sub, 10 sat add, 11 sat sub
//   out_valid/out_ready result handshake (out, positive/negative_overflow)
//   clr_sticky          clears sticky_pos / sticky_neg
//   sticky_pos/neg      an overflow of that sign was delivered since clear
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             positive_overflow,
  output logic             negative_overflow,
  input  logic             clr_sticky,
  output logic             sticky_pos,
  output logic             sticky_neg
);

  localparam int SLICE = WIDTH / STAGES;

  logic stall;

  // Stage-input bundles. Index 0 comes straight from the ports. Index k > 0
  // is the register bank written by stage k-1. The operands travel with the
  // beat so each stage can pick out its own slice.
  logic             st_v  [STAGES];
  logic [1:0]       st_op [STAGES];
  logic [WIDTH-1:0] st_a  [STAGES];
  logic [WIDTH-1:0] st_b  [STAGES];
  logic [WIDTH-1:0] st_s  [STAGES];
  logic             st_c  [STAGES];

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // For subtraction the carry-in of slice 0 supplies the +1 of the two's complement.
  assign st_v[0]  = in_valid & in_ready;
  assign st_op[0] = op;
  assign st_a[0]  = a;
  assign st_b[0]  = b;
  assign st_s[0]  = '0;
  assign st_c[0]  = op[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic             c_out;
    logic [WIDTH-1:0] s_new;

    assign a_sl = st_a[k][k*SLICE +: SLICE];
    assign b_sl = st_op[k][0] ? ~st_b[k][k*SLICE +: SLICE] : st_b[k][k*SLICE +: SLICE];
    assign {c_out, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, st_c[k]};

    always_comb begin
      s_new = st_s[k];
      s_new[k*SLICE +: SLICE] = s_sl;
    end

    if (k < STAGES - 1) begin : g_mid
      logic             v_q;
      logic [1:0]       op_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q  <= 1'b0;
          op_q <= '0;
          a_q  <= '0;
          b_q  <= '0;
          s_q  <= '0;
          c_q  <= 1'b0;
        end else if (!stall) begin
          v_q  <= st_v[k];
          op_q <= st_op[k];
          a_q  <= st_a[k];
          b_q  <= st_b[k];
          s_q  <= s_new;
          c_q  <= c_out;
        end
      end

      assign st_v[k+1]  = v_q;
      assign st_op[k+1] = op_q;
      assign st_a[k+1]  = a_q;
      assign st_b[k+1]  = b_q;
      assign st_s[k+1]  = s_q;
      assign st_c[k+1]  = c_q;
    end else begin : g_last
      logic             b_ext;
      logic             ext;
      logic             pos;
      logic             neg;
      logic [WIDTH-1:0] result;

      // Bit WIDTH of the extended sum. Its operands are the sign bits
      // repeated, so the top-slice carry resolves it without a wider adder.
      assign b_ext = st_op[k][0] ? ~st_b[k][WIDTH-1] : st_b[k][WIDTH-1];
      assign ext   = st_a[k][WIDTH-1] ^ b_ext ^ c_out;
      assign pos   = ({ext, s_new[WIDTH-1]} == 2'b01);
      assign neg   = ({ext, s_new[WIDTH-1]} == 2'b10);

      always_comb begin
        result = s_new;
        if (st_op[k][1] && pos) begin
          result = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (st_op[k][1] && neg) begin
          result = {1'b1, {(WIDTH-1){1'b0}}};
        end
      end

      // Bubbles load zeros so that out and flags read 0 whenever out_valid is 0.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid         <= 1'b0;
          out               <= '0;
          positive_overflow <= 1'b0;
          negative_overflow <= 1'b0;
        end else if (!stall) begin
          out_valid         <= st_v[k];
          out               <= st_v[k] ? result : '0;
          positive_overflow <= st_v[k] & pos;
          negative_overflow <= st_v[k] & neg;
        end
      end
    end
  end

  // Sticky flags. A delivered overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_pos <= 1'b0;
      sticky_neg <= 1'b0;
    end else begin
      if (out_valid && out_ready && positive_overflow) begin
        sticky_pos <= 1'b1;
      end else if (clr_sticky) begin
        sticky_pos <= 1'b0;
      end
      if (out_valid && out_ready && negative_overflow) begin
        sticky_neg <= 1'b1;
      end else if (clr_sticky) begin
        sticky_neg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Testbench for pipe_addsub (WIDTH=32, STAGES=2). The DUT is compared with
// an arithmetic reference model. The model works on the exact signed
// result in 64 bits.
module tb_pipe_addsub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       op = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out;
  logic             positive_overflow;
  logic             negative_overflow;
  logic             clr_sticky = 1'b0;
  logic             sticky_pos;
  logic             sticky_neg;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             pos;
    logic             neg;
  } exp_t;

  exp_t expQ [$];
  int   nChecks = 0;
  int   nFails  = 0;

  logic             prevStall = 1'b0;
  logic [WIDTH-1:0] prevOut   = '0;
  logic [1:0]       prevFlags = '0;

  pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out),
    .positive_overflow(positive_overflow), .negative_overflow(negative_overflow),
    .clr_sticky(clr_sticky), .sticky_pos(sticky_pos), .sticky_neg(sticky_neg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] expv);
    nChecks++;
    if (got !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference: exact signed result, range check, then wrap or saturate.
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic [1:0] mop);
    exp_t   e;
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    r  = mop[0] ? sa - sb : sa + sb;
    e.pos = (r > 64'sd2147483647);
    e.neg = (r < -64'sd2147483648);
    e.res = r[WIDTH-1:0];
    if (mop[1] && e.pos) e.res = 32'h7FFF_FFFF;
    if (mop[1] && e.neg) e.res = 32'h8000_0000;
    return e;
  endfunction

  // Monitor. It runs on the falling edge, between the driving and active edges.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
      if (!out_valid) checkOutput("idle_flags", {30'b0, positive_overflow, negative_overflow}, '0);
      if (prevStall) begin
        checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("hold_out", out, prevOut);
        checkOutput("hold_flags", {30'b0, positive_overflow, negative_overflow}, {30'b0, prevFlags});
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", expQ.size(), 32'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_out", out, e.res);
          checkOutput("sb_flags", {30'b0, positive_overflow, negative_overflow}, {30'b0, e.pos, e.neg});
        end
      end
      if (in_valid && in_ready) expQ.push_back(model(a, b, op));
      prevStall = out_valid && !out_ready;
      prevOut   = out;
      prevFlags = {positive_overflow, negative_overflow};
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                               input logic [1:0] top);
    a = ta;
    b = tb;
    op = top;
    in_valid = 1'b1;
  endtask

  // A single beat into an empty pipe. The result must appear STAGES edges after acceptance.
  task automatic runDirected(input string tag, input logic [WIDTH-1:0] ta,
                             input logic [WIDTH-1:0] tb, input logic [1:0] top,
                             input logic [WIDTH-1:0] expOut, input logic expPos,
                             input logic expNeg);
    applyStimulus(ta, tb, top);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({tag, "_early"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, "_out"}, out, expOut);
    checkOutput({tag, "_pos"}, {31'b0, positive_overflow}, {31'b0, expPos});
    checkOutput({tag, "_neg"}, {31'b0, negative_overflow}, {31'b0, expNeg});
  endtask

  // Streams beats with held inputs until accepted. stallAt >= 0 forces
  // out_ready low for three cycles from that cycle; otherwise it is random.
  task automatic runStream(input int nBeats, input int stallAt, input logic randOp);
    int  sent;
    int  cyc;
    logic acc;
    sent = 0;
    cyc  = 0;
    while ((sent < nBeats || expQ.size() > 0 || out_valid) && cyc < 500) begin
      if (stallAt >= 0) out_ready = !(cyc >= stallAt && cyc < stallAt + 3);
      else              out_ready = ($urandom_range(9) < 7);
      if (sent < nBeats) begin
        case ($urandom_range(3))
          0: applyStimulus(32'h7FFF_FFF0 + $urandom_range(15), $urandom_range(31), 2'($urandom));
          1: applyStimulus(32'h8000_0000 + $urandom_range(15), 32'hFFFF_FFF0 + $urandom_range(15), 2'($urandom));
          default: applyStimulus($urandom, $urandom, 2'($urandom));
        endcase
        if (!randOp) op = 2'($urandom_range(1));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_sent", sent, nBeats);
    checkOutput("stream_drain", expQ.size(), 32'd0);
  endtask

  initial begin
    #2;
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out", out, 32'd0);
    checkOutput("rst_flags", {28'b0, positive_overflow, negative_overflow, sticky_pos, sticky_neg}, 32'd0);
    checkOutput("rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    runDirected("add_ovf",  32'h7FFF_FFFF, 32'd1,         2'b00, 32'h8000_0000, 1'b1, 1'b0);
    runDirected("sadd_ovf", 32'h7FFF_FFFF, 32'd1,         2'b10, 32'h7FFF_FFFF, 1'b1, 1'b0);
    runDirected("sub_min",  32'd0,         32'h8000_0000, 2'b01, 32'h8000_0000, 1'b1, 1'b0);
    runDirected("ssub_min", 32'd0,         32'h8000_0000, 2'b11, 32'h7FFF_FFFF, 1'b1, 1'b0);
    runDirected("add_neg",  32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h7FFF_FFFF, 1'b0, 1'b1);
    runDirected("sadd_neg", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000, 1'b0, 1'b1);
    runDirected("carry",    32'h0000_FFFF, 32'd1,         2'b00, 32'h0001_0000, 1'b0, 1'b0);
    runDirected("sub_small", 32'd5,        32'd7,         2'b01, 32'hFFFF_FFFE, 1'b0, 1'b0);

    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checkOutput("sticky_clr0", {30'b0, sticky_pos, sticky_neg}, 32'd0);
    applyStimulus(32'h7FFF_FFFF, 32'd1, 2'b00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr_sticky = 1'b1;
    checkOutput("sticky_pre", {31'b0, sticky_pos}, 32'd0);
    @(posedge clk); #1;
    checkOutput("sticky_setwins", {31'b0, sticky_pos}, 32'd1);
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checkOutput("sticky_cleared", {31'b0, sticky_pos}, 32'd0);

    runStream(8, 3, 1'b1);
    runStream(40, -1, 1'b1);

    applyStimulus(32'd1, 32'd2, 2'b00);
    @(posedge clk); #1;
    applyStimulus(32'h7FFF_FFFF, 32'd5, 2'b00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("mrst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mrst_out", out, 32'd0);
    checkOutput("mrst_flags", {28'b0, positive_overflow, negative_overflow, sticky_pos, sticky_neg}, 32'd0);
    checkOutput("mrst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("mrst_nostale", {31'b0, out_valid}, 32'd0);
    runDirected("mrst_new", 32'd3, 32'd4, 2'b00, 32'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("final_drain", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
